// File: rtl/prio_enc_pkg.sv
// Shared definitions for the prio_encoder_rr slice: mode encodings and the one-hot helper.
package prio_enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Widest request vector the one-hot helper supports.
    localparam int unsigned MAX_N = 64;
    localparam int unsigned MAX_W = 6;

    function automatic logic [MAX_N-1:0] onehot_from_idx(input logic [MAX_W-1:0] i);
        logic [MAX_N-1:0] one;
        one = {{(MAX_N-1){1'b0}}, 1'b1};
        return one << i;
    endfunction

endpackage

// File: rtl/prio_scan.sv
// Combinational wrapping downward search: first set bit at start_i, start_i-1, ... start_i+1.
module prio_scan #(
    parameter int unsigned N = 8,
    localparam int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] start_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);

    int pos;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        pos     = 0;
        // Walk from lowest to highest priority so the last hit is the winner.
        for (int k = int'(N) - 1; k >= 0; k--) begin
            pos = (int'(start_i) + int'(N) - k) % int'(N);
            if (req_i[pos]) begin
                found_o = 1'b1;
                idx_o   = W'(pos);
            end
        end
    end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-input priority encoder with valid/ready output stage.
// Round-robin mode and the ptr register are built only when PRIO_ENC_RR_EN is defined.
module prio_encoder_rr
    import prio_enc_pkg::*;
#(
    parameter int unsigned N = 8,
    localparam int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         out_ready,
    output logic [W-1:0] idx,
    output logic [N-1:0] grant,
    output logic         valid
);

    logic [W-1:0] idx_q, idx_d;
    logic [N-1:0] grant_q, grant_d;
    logic         valid_q, valid_d;

    logic         cap;
    logic         xfer;
    logic [W-1:0] start;
    logic         found;
    logic [W-1:0] scan_idx;

    assign cap  = !valid_q || out_ready;
    assign xfer = valid_q && out_ready;

`ifdef PRIO_ENC_RR_EN
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] base;

    // Using idx on transfer lets back-to-back grants rotate without waiting for ptr.
    assign base  = xfer ? idx_q : ptr_q;
    assign ptr_d = xfer ? idx_q : ptr_q;

    always_comb begin
        if (mode == MODE_RR) begin
            start = (base == '0) ? W'(N - 1) : base - 1'b1;
        end else begin
            start = W'(N - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign start       = W'(N - 1);
`endif

    prio_scan #(
        .N(N)
    ) u_scan (
        .req_i   (req),
        .start_i (start),
        .found_o (found),
        .idx_o   (scan_idx)
    );

    always_comb begin
        idx_d   = idx_q;
        grant_d = grant_q;
        valid_d = valid_q;
        if (cap) begin
            valid_d = found;
            if (found) begin
                idx_d   = scan_idx;
                grant_d = N'(onehot_from_idx(MAX_W'(scan_idx)));
            end else begin
                grant_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
        end
    end

    assign idx   = idx_q;
    assign grant = grant_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Table-driven scoreboard bench for prio_encoder_rr (N=8); expectations follow PRIO_ENC_RR_EN.
module tb_prio_encoder_rr;

    localparam int unsigned N = 8;
`ifdef PRIO_ENC_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         mode;
    logic         out_ready;
    logic [2:0]   idx;
    logic [N-1:0] grant;
    logic         valid;

    always #5 clk = ~clk;

    prio_encoder_rr #(
        .N(N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mode      (mode),
        .out_ready (out_ready),
        .idx       (idx),
        .grant     (grant),
        .valid     (valid)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic [7:0] req;
        logic       mode;
        logic       rdy;
        logic       ev;
        int         eidx;
    } vec_t;

    typedef struct {
        string      name;
        logic       v;
        logic [2:0] i;
        logic [7:0] g;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input string nm, input logic r, input logic [7:0] q, input logic m,
                       input logic o, input logic ev, input int ei);
        vec_t t;
        t.name = nm; t.rst = r; t.req = q; t.mode = m; t.rdy = o; t.ev = ev; t.eidx = ei;
        vecs.push_back(t);
    endtask

    task automatic check_out();
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: no expected entry for output sample");
        end else begin
            e = sb.pop_front();
            if (valid !== e.v || grant !== e.g || (e.v && idx !== e.i) || idx !== e.i) begin
                n_err++;
                $display("FAIL %s: got valid=%0b idx=%0d grant=%h, required valid=%0b idx=%0d grant=%h",
                         e.name, valid, idx, grant, e.v, e.i, e.g);
            end
        end
    endtask

    task automatic apply(input vec_t t);
        exp_t       e;
        logic [7:0] one;
        rst = t.rst; req = t.req; mode = t.mode; out_ready = t.rdy;
        one    = 8'h01;
        e.name = t.name;
        e.v    = t.ev;
        e.i    = 3'(t.eidx);
        e.g    = t.ev ? (one << t.eidx) : 8'h00;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 8'h00; mode = 1'b0; out_ready = 1'b1;

        // name          rst  req    mode rdy  valid idx
        add("reset0",     1, 8'hFF, 0, 1, 0, 0);
        add("reset1",     1, 8'hFF, 0, 1, 0, 0);
        add("first_cap",  0, 8'hFF, 0, 1, 1, 7);
        add("fix_81",     0, 8'h81, 0, 1, 1, 7);
        add("fix_zero",   0, 8'h00, 0, 1, 0, 7);
        add("stall_cap",  0, 8'h10, 0, 0, 1, 4);
        add("stall_h1",   0, 8'h01, 0, 0, 1, 4);
        add("stall_h2",   0, 8'h01, 0, 0, 1, 4);
        add("stall_h3",   0, 8'h01, 0, 0, 1, 4);
        add("stall_rel",  0, 8'h01, 0, 1, 1, 0);
        add("drain",      0, 8'h00, 0, 1, 0, 0);
        add("rr_full0",   0, 8'hFF, 1, 1, 1, 7);
        add("rr_full1",   0, 8'hFF, 1, 1, 1, RR ? 6 : 7);
        add("rr_full2",   0, 8'hFF, 1, 1, 1, RR ? 5 : 7);
        add("rr_full3",   0, 8'hFF, 1, 1, 1, RR ? 4 : 7);
        add("rr_full4",   0, 8'hFF, 1, 1, 1, RR ? 3 : 7);
        add("rr_full5",   0, 8'hFF, 1, 1, 1, RR ? 2 : 7);
        add("rr_full6",   0, 8'hFF, 1, 1, 1, RR ? 1 : 7);
        add("rr_full7",   0, 8'hFF, 1, 1, 1, RR ? 0 : 7);
        add("rr_wrap",    0, 8'hFF, 1, 1, 1, 7);
        add("sp_reset",   1, 8'h84, 1, 1, 0, 0);
        add("sparse0",    0, 8'h84, 1, 1, 1, 7);
        add("sparse1",    0, 8'h84, 1, 1, 1, RR ? 2 : 7);
        add("sparse2",    0, 8'h84, 1, 1, 1, 7);
        add("sparse3",    0, 8'h84, 1, 1, 1, RR ? 2 : 7);

        foreach (vecs[k]) apply(vecs[k]);
        vecs.delete();

        // Reset in the middle of a round-robin run, once idx=5 has gone out.
        add("mid0",       0, 8'hFF, 1, 1, 1, RR ? 1 : 7);
        add("mid1",       0, 8'hFF, 1, 1, 1, RR ? 0 : 7);
        add("mid2",       0, 8'hFF, 1, 1, 1, 7);
        add("mid3",       0, 8'hFF, 1, 1, 1, RR ? 6 : 7);
        add("mid4",       0, 8'hFF, 1, 1, 1, RR ? 5 : 7);
        add("mid_rst",    1, 8'hFF, 1, 1, 0, 0);
        add("mid_after",  0, 8'hFF, 1, 1, 1, 7);
        foreach (vecs[k]) apply(vecs[k]);
        vecs.delete();

        // Mode switch keeps ptr; xfer with req=0 still updates ptr; stall in RR mode.
        add("sw_fixed",   0, 8'hFF, 0, 1, 1, 7);
        add("sw_rr",      0, 8'hFF, 1, 1, 1, RR ? 6 : 7);
        add("xfer_zero",  0, 8'h00, 1, 1, 0, RR ? 6 : 7);
        add("ptr_used",   0, 8'hFF, 1, 1, 1, RR ? 5 : 7);
        add("rr_stall",   0, 8'h01, 1, 0, 1, RR ? 5 : 7);
        add("rr_resume",  0, 8'hFF, 1, 1, 1, RR ? 4 : 7);
        foreach (vecs[k]) apply(vecs[k]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prio_encoder_rr.md
# prio_encoder_rr

Parametrised, registered N-input priority encoder with a valid/ready output stage and an optional round-robin mode. It turns a request vector into a binary index plus a one-hot grant, so the encoded result can feed arbiters and interrupt/event selectors downstream. Fixed-priority mode matches the team's 8:3 encoder convention: the highest-numbered asserted bit wins. Round-robin mode rotates priority after each accepted grant so no requester starves.

## Interface
- N, default 8: number of request lines; N ≥ 2.
- W, derived localparam $clog2(N): index width; not overridable.
- clk  input  1  rising-edge clock; the block has one clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit k means requester k is asserting.
- mode  input  1  0 = fixed priority, 1 = round-robin; ignored when round-robin is compiled out.
- out_ready  input  1  downstream accepts the current result.
- idx  output  W  registered binary index of the granted request.
- grant  output  N  registered one-hot grant; equals 1<<idx when valid, else 0.
- valid  output  1  idx/grant hold a grant.

## Operation
- **Capture condition:** cap = !valid || out_ready. On every clk edge with cap=1, the output register loads the encode of the current req.
- **Transfer:** xfer = valid && out_ready, evaluated before the edge.
- **Fixed mode:** the search starts at bit N-1 and goes downward. The first set bit wins.
- **Round-robin mode:** the search starts at bit (base-1) mod N and goes downward with wrap. It covers all N bits, so bit base is checked last.
  - base = xfer ? idx : ptr.
  - ptr register, W bits: on xfer, ptr <= idx.
- **req == 0 at capture:** valid <= 0, grant <= 0, idx holds its last value (no Z output, unlike the predecessor).
- **Stall:** while valid && !out_ready, idx, grant and valid are frozen regardless of req or mode changes.
- **Mode switch:** takes effect at the next capture; ptr is retained across switches.
- **Reset:** valid=0, grant=0, idx=0, ptr=0. With ptr=0 the round-robin search starts at N-1, identical to fixed priority.
- **Reset mid-operation:** rst overrides cap and xfer. All state returns to reset values at that edge, and any pending result is dropped.

## Timing
- Latency: req to idx/grant/valid is 1 cycle when unstalled.
- Throughput: one grant per cycle with out_ready held high.
- All outputs come from flops; there are no combinational paths from inputs to outputs.
- The ptr update and the new capture occur on the same edge. The capture uses base = idx (the just-transferred index), so back-to-back round-robin grants rotate without a bubble.
- Simultaneous xfer with req=0 gives valid=0 next cycle, with ptr updated.

## Configuration
- Macro: PRIO_ENC_RR_EN.
- **Defined:** round-robin logic and the ptr register are built, and the mode port selects between fixed and round-robin.
- **Undefined:** no ptr register; the mode port exists but is ignored. Behaviour is fixed priority only, and all other timing is identical.

## Structure
- Shared package prio_enc_pkg:
  - MODE_FIXED = 1'b0, MODE_RR = 1'b1.
  - a one-hot-from-index helper function.
- Sub-module prio_scan: combinational wrapping downward search over N bits.
  - Inputs: req and start index.
  - Outputs: found and index.
  - Fixed mode drives start = N-1.
  - The top level holds only the flops, the handshake and the ptr.

## Test plan
- **Reset:** hold rst 2 cycles with req=8'hFF -> valid=0, grant=8'h00, idx=0. First capture after release gives idx=7.
- **Fixed mode, out_ready=1:** req=8'b1000_0001 -> next cycle idx=7, grant=8'h80, valid=1. Then req=0 -> valid=0, grant=0, idx stays 7.
- **Stall:** req=8'h10, out_ready=0 -> idx=4, valid=1. Change req to 8'h01 and hold 3 cycles -> idx stays 4. Raise out_ready -> next cycle idx=0.
- **Round-robin full load:** mode=1, req=8'hFF, out_ready=1 -> idx sequence 7,6,5,4,3,2,1,0,7 with no bubbles.
- **Round-robin sparse:** mode=1, req=8'b1000_0100 -> idx alternates 7,2,7,2. With the macro undefined, the same stimulus gives 7,7,7,7.
- **Reset mid round-robin:** after idx=5 is transferred, assert rst for 1 cycle with req=8'hFF -> valid=0, then the first grant is idx=7.
